// File: rtl/control_multiciclo.sv
// Moore FSM control unit for the multicycle MIPS core: sequences shared memory, ULA, regfile and PC.
// Memory states wait on mem_ready and abort to FETCH after TIMEOUT cycles (0 disables the abort).
module control_multiciclo #(
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_EXEC_I    = 4'd11;
  localparam logic [3:0] S_I_WB      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0100;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [3:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    w_next;
  logic          w_is_mem;
  logic          w_timeout;

  assign w_is_mem  = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
  // mem_ready wins over an expiring counter in the same cycle.
  assign w_timeout = (TIMEOUT != 0) && w_is_mem && !mem_ready && (r_cnt == CNT_MAX);
  assign state       = r_state;
  assign mem_timeout = w_timeout;

  always_comb begin
    w_next     = r_state;
    PCEn       = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 2'b00;
    MemToReg   = 2'b00;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = ALU_ADD;
    PCSource   = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCEn    = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:            w_next = S_MEM_ADDR;
          OP_RTYPE:                w_next = S_EXEC_R;
          OP_BEQ, OP_BNE:          w_next = S_BRANCH;
          OP_J:                    w_next = S_JUMP;
          OP_JAL:                  w_next = S_JAL;
          OP_ADDI, OP_ORI, OP_SLTI: w_next = S_EXEC_I;
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opcode == OP_SW) ? S_MEM_WRITE : (opcode == OP_LW) ? S_MEM_READ : S_FETCH;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemToReg   = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
        w_next  = S_R_WB;
      end
      S_R_WB: begin
        RegDst     = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_SUB;
        PCSource   = 2'b01;
        PCEn       = (opcode == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCEn       = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        RegDst     = 2'b10;
        MemToReg   = 2'b10;
        RegWrite   = 1'b1;
        PCSource   = 2'b10;
        PCEn       = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode == OP_ORI) ? ALU_OR : (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        w_next  = S_I_WB;
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Aborted memory access: refetch the same PC with nothing committed.
    if (w_timeout) begin
      w_next     = S_FETCH;
      PCEn       = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
    end
    if (reset) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Any state change (or a self-loop abort in FETCH) starts a fresh wait.
      if (w_timeout || (w_next != r_state)) r_cnt <= '0;
      else if (w_is_mem && !mem_ready && (TIMEOUT != 0)) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
